// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, control-field layout and the
// main control decoder.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Bit positions inside the wb / mem / ex control groups
    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;
    localparam int EX_REGDST    = 3;
    localparam int EX_ALUOP_HI  = 2;
    localparam int EX_ALUOP_LO  = 1;
    localparam int EX_ALUSRC    = 0;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [3:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{wb: 2'b00, mem: 3'b000, ex: 4'b0000};

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: c = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100};
            OP_LW:    c = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001};
            OP_SW:    c = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001};
            OP_BEQ:   c = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010};
            OP_ADDI:  c = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001};
            default:  c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hz_reg_file.sv
// 32-entry register file, two combinational read ports, one write port, with
// optional same-cycle write-through from WB to the read ports.
module hz_reg_file #(
    parameter int DATA_W    = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr_1,
    input  logic [4:0]        raddr_2,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is hard-wired, so it must also be excluded from the bypass match
    always_comb begin
        rdata_1 = (raddr_1 == 5'd0) ? '0 : regs[raddr_1];
        rdata_2 = (raddr_2 == 5'd0) ? '0 : regs[raddr_2];
        if (BYPASS_EN != 0 && we) begin
            if (raddr_1 != 5'd0 && raddr_1 == waddr) rdata_1 = wdata;
            if (raddr_2 != 5'd0 && raddr_2 == waddr) rdata_2 = wdata;
        end
    end

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS ID stage: register read, control decode, sign extension, load-use
// hazard detection and the ID/EX pipeline latch.
module decode_stage_hz #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int BYPASS_EN   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_write_reg_location,
    input  logic [DATA_W-1:0]      mem_wb_write_data,
    input  logic [31:0]            if_id_instr,
    input  logic [PC_W-1:0]        if_id_npc,
    input  logic                   if_id_valid,
    input  logic                   flush,
    output logic                   hazard_stall,
    output logic                   id_ex_valid,
    output logic [1:0]             id_ex_wb,
    output logic [2:0]             id_ex_mem,
    output logic [3:0]             id_ex_execute,
    output logic [PC_W-1:0]        id_ex_npc,
    output logic [DATA_W-1:0]      id_ex_read_data_1,
    output logic [DATA_W-1:0]      id_ex_read_data_2,
    output logic [DATA_W-1:0]      id_ex_sign_ext,
    output logic [4:0]             id_ex_instr_bits_25_21,
    output logic [4:0]             id_ex_instr_bits_20_16,
    output logic [4:0]             id_ex_instr_bits_15_11,
    output logic [STALL_CNT_W-1:0] stall_count
);
    import decode_pkg::*;

    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rdata_1, rdata_2, sext;
    ctrl_t             ctrl;

    assign rs   = if_id_instr[25:21];
    assign rt   = if_id_instr[20:16];
    assign rd   = if_id_instr[15:11];
    assign imm  = if_id_instr[15:0];
    assign sext = {{(DATA_W-16){imm[15]}}, imm};
    assign ctrl = decode_ctrl(if_id_instr[31:26]);

    hz_reg_file #(
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_reg_write),
        .waddr   (wb_write_reg_location),
        .wdata   (mem_wb_write_data),
        .raddr_1 (rs),
        .raddr_2 (rt),
        .rdata_1 (rdata_1),
        .rdata_2 (rdata_2)
    );

    // A load targeting r0 produces nothing, so it never creates a dependency
    assign hazard_stall = id_ex_valid & id_ex_mem[MEM_MEMREAD] & if_id_valid &
                          (id_ex_instr_bits_20_16 != 5'd0) &
                          ((id_ex_instr_bits_20_16 == rs) |
                           (id_ex_instr_bits_20_16 == rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_valid            <= 1'b0;
            id_ex_wb               <= '0;
            id_ex_mem              <= '0;
            id_ex_execute          <= '0;
            id_ex_npc              <= '0;
            id_ex_read_data_1      <= '0;
            id_ex_read_data_2      <= '0;
            id_ex_sign_ext         <= '0;
            id_ex_instr_bits_25_21 <= '0;
            id_ex_instr_bits_20_16 <= '0;
            id_ex_instr_bits_15_11 <= '0;
        end else if (flush || hazard_stall) begin
            id_ex_valid            <= 1'b0;
            id_ex_wb               <= '0;
            id_ex_mem              <= '0;
            id_ex_execute          <= '0;
            id_ex_npc              <= '0;
            id_ex_read_data_1      <= '0;
            id_ex_read_data_2      <= '0;
            id_ex_sign_ext         <= '0;
            id_ex_instr_bits_25_21 <= '0;
            id_ex_instr_bits_20_16 <= '0;
            id_ex_instr_bits_15_11 <= '0;
        end else begin
            id_ex_valid            <= if_id_valid;
            id_ex_wb               <= if_id_valid ? ctrl.wb  : CTRL_NOP.wb;
            id_ex_mem              <= if_id_valid ? ctrl.mem : CTRL_NOP.mem;
            id_ex_execute          <= if_id_valid ? ctrl.ex  : CTRL_NOP.ex;
            id_ex_npc              <= if_id_npc;
            id_ex_read_data_1      <= rdata_1;
            id_ex_read_data_2      <= rdata_2;
            id_ex_sign_ext         <= sext;
            id_ex_instr_bits_25_21 <= rs;
            id_ex_instr_bits_20_16 <= rt;
            id_ex_instr_bits_15_11 <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (hazard_stall && stall_count != {STALL_CNT_W{1'b1}}) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: default build, a no-bypass build and a
// 2-bit stall counter build all share one stimulus stream.
module tb_decode_stage_hz;
    import decode_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wb_reg_write, if_id_valid, flush;
    logic [4:0]  wb_loc;
    logic [31:0] wb_data, instr, npc;

    logic        d_stall, d_valid;
    logic [1:0]  d_wb;
    logic [2:0]  d_mem;
    logic [3:0]  d_ex;
    logic [31:0] d_npc, d_rd1, d_rd2, d_se;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic [15:0] d_cnt;

    logic        n_stall, n_valid;
    logic [1:0]  n_wb;
    logic [2:0]  n_mem;
    logic [3:0]  n_ex;
    logic [31:0] n_npc, n_rd1, n_rd2, n_se;
    logic [4:0]  n_rs, n_rt, n_rd;
    logic [15:0] n_cnt;

    logic        s_stall, s_valid;
    logic [1:0]  s_wb;
    logic [2:0]  s_mem;
    logic [3:0]  s_ex;
    logic [31:0] s_npc, s_rd1, s_rd2, s_se;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_cnt;

    decode_stage_hz u_dut (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc),
        .mem_wb_write_data(wb_data), .if_id_instr(instr), .if_id_npc(npc),
        .if_id_valid(if_id_valid), .flush(flush), .hazard_stall(d_stall),
        .id_ex_valid(d_valid), .id_ex_wb(d_wb), .id_ex_mem(d_mem), .id_ex_execute(d_ex),
        .id_ex_npc(d_npc), .id_ex_read_data_1(d_rd1), .id_ex_read_data_2(d_rd2),
        .id_ex_sign_ext(d_se), .id_ex_instr_bits_25_21(d_rs), .id_ex_instr_bits_20_16(d_rt),
        .id_ex_instr_bits_15_11(d_rd), .stall_count(d_cnt)
    );

    decode_stage_hz #(.BYPASS_EN(0)) u_nb (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc),
        .mem_wb_write_data(wb_data), .if_id_instr(instr), .if_id_npc(npc),
        .if_id_valid(if_id_valid), .flush(flush), .hazard_stall(n_stall),
        .id_ex_valid(n_valid), .id_ex_wb(n_wb), .id_ex_mem(n_mem), .id_ex_execute(n_ex),
        .id_ex_npc(n_npc), .id_ex_read_data_1(n_rd1), .id_ex_read_data_2(n_rd2),
        .id_ex_sign_ext(n_se), .id_ex_instr_bits_25_21(n_rs), .id_ex_instr_bits_20_16(n_rt),
        .id_ex_instr_bits_15_11(n_rd), .stall_count(n_cnt)
    );

    decode_stage_hz #(.STALL_CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc),
        .mem_wb_write_data(wb_data), .if_id_instr(instr), .if_id_npc(npc),
        .if_id_valid(if_id_valid), .flush(flush), .hazard_stall(s_stall),
        .id_ex_valid(s_valid), .id_ex_wb(s_wb), .id_ex_mem(s_mem), .id_ex_execute(s_ex),
        .id_ex_npc(s_npc), .id_ex_read_data_1(s_rd1), .id_ex_read_data_2(s_rd2),
        .id_ex_sign_ext(s_se), .id_ex_instr_bits_25_21(s_rs), .id_ex_instr_bits_20_16(s_rt),
        .id_ex_instr_bits_15_11(s_rd), .stall_count(s_cnt)
    );

    int pass_cnt = 0;
    int total    = 0;
    int stalls   = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {OP_RTYPE, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] ins);
        if_id_valid = v;
        instr       = ins;
    endtask

    task automatic bubble();
        drive_id(1'b0, 32'd0);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; wb_reg_write = 1'b0; wb_loc = '0; wb_data = '0;
        instr = '0; npc = '0; if_id_valid = 1'b0; flush = 1'b0;
        #1;
        total++;
        if ({d_valid, d_wb, d_mem, d_ex} !== 10'd0)
            $display("FAIL reset_ctrl: got %b exp 0", {d_valid, d_wb, d_mem, d_ex});
        else pass_cnt++;
        total++;
        if (d_cnt !== 16'd0 || s_cnt !== 2'd0)
            $display("FAIL reset_cnt: got %0d/%0d exp 0/0", d_cnt, s_cnt);
        else pass_cnt++;
        total++;
        if (d_npc !== 32'd0 || d_rd1 !== 32'd0 || d_se !== 32'd0)
            $display("FAIL reset_data: got %h %h %h exp 0", d_npc, d_rd1, d_se);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_decode();
        logic [31:0] ins [6];
        logic [8:0]  ctl [6];
        logic [31:0] se  [6];
        ins[0] = rtype(5'd1, 5'd3, 5'd9);                  ctl[0] = 9'b10_000_1100; se[0] = 32'h0000_4820;
        ins[1] = itype(OP_LW,   5'd1, 5'd2, 16'h8004);     ctl[1] = 9'b11_010_0001; se[1] = 32'hFFFF_8004;
        ins[2] = itype(OP_SW,   5'd3, 5'd4, 16'h0010);     ctl[2] = 9'b00_001_0001; se[2] = 32'h0000_0010;
        ins[3] = itype(OP_BEQ,  5'd5, 5'd6, 16'hFFFF);     ctl[3] = 9'b00_100_0010; se[3] = 32'hFFFF_FFFF;
        ins[4] = itype(OP_ADDI, 5'd7, 5'd8, 16'h7FFF);     ctl[4] = 9'b10_000_0001; se[4] = 32'h0000_7FFF;
        ins[5] = itype(6'h3F,   5'd9, 5'd10, 16'h0000);    ctl[5] = 9'b00_000_0000; se[5] = 32'h0000_0000;
        for (int i = 0; i < 6; i++) begin
            drive_id(1'b1, ins[i]);
            npc = 32'h100 + 32'(4 * i);
            step();
            total++;
            if ({d_wb, d_mem, d_ex} !== ctl[i] || d_valid !== 1'b1)
                $display("FAIL decode_ctrl[%0d]: got %b v%b exp %b v1", i, {d_wb, d_mem, d_ex}, d_valid, ctl[i]);
            else pass_cnt++;
            total++;
            if (d_se !== se[i] || d_npc !== 32'h100 + 32'(4 * i) || d_rs !== ins[i][25:21] || d_rt !== ins[i][20:16])
                $display("FAIL decode_data[%0d]: se %h npc %h rs %0d rt %0d exp se %h", i, d_se, d_npc, d_rs, d_rt, se[i]);
            else pass_cnt++;
        end
        drive_id(1'b0, itype(OP_LW, 5'd1, 5'd2, 16'h4));
        step();
        total++;
        if ({d_valid, d_wb, d_mem, d_ex} !== 10'd0)
            $display("FAIL invalid_slot: got %b exp 0", {d_valid, d_wb, d_mem, d_ex});
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        bubble();
        wb_reg_write = 1'b1; wb_loc = 5'd3; wb_data = 32'hDEAD_BEEF;
        drive_id(1'b1, rtype(5'd3, 5'd0, 5'd1));
        step();
        total++;
        if (d_rd1 !== 32'hDEAD_BEEF || d_rd2 !== 32'd0)
            $display("FAIL bypass_on: got %h %h exp deadbeef 0", d_rd1, d_rd2);
        else pass_cnt++;
        total++;
        if (n_rd1 !== 32'd0)
            $display("FAIL bypass_off: got %h exp 0", n_rd1);
        else pass_cnt++;
        wb_reg_write = 1'b0;
        step();
        total++;
        if (n_rd1 !== 32'hDEAD_BEEF)
            $display("FAIL bypass_stored: got %h exp deadbeef", n_rd1);
        else pass_cnt++;
    endtask

    task automatic test_reg0();
        wb_reg_write = 1'b1; wb_loc = 5'd0; wb_data = 32'h0000_1234;
        drive_id(1'b1, rtype(5'd0, 5'd0, 5'd1));
        step();
        total++;
        if (d_rd1 !== 32'd0)
            $display("FAIL r0_bypass: got %h exp 0", d_rd1);
        else pass_cnt++;
        wb_reg_write = 1'b0;
        step();
        total++;
        if (d_rd1 !== 32'd0 || n_rd1 !== 32'd0)
            $display("FAIL r0_write: got %h %h exp 0", d_rd1, n_rd1);
        else pass_cnt++;
        drive_id(1'b1, itype(OP_LW, 5'd1, 5'd0, 16'h4));
        step();
        drive_id(1'b1, rtype(5'd0, 5'd0, 5'd5));
        #1;
        total++;
        if (d_stall !== 1'b0)
            $display("FAIL r0_no_stall: got %b exp 0", d_stall);
        else pass_cnt++;
        step();
        total++;
        if (d_valid !== 1'b1 || d_rd !== 5'd5)
            $display("FAIL r0_consumer: got v%b rd%0d exp v1 rd5", d_valid, d_rd);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        drive_id(1'b1, itype(OP_LW, 5'd1, 5'd2, 16'h4));
        step();
        drive_id(1'b1, rtype(5'd2, 5'd5, 5'd4));
        #1;
        total++;
        if (d_stall !== 1'b1)
            $display("FAIL lu_stall: got %b exp 1", d_stall);
        else pass_cnt++;
        step();
        stalls++;
        total++;
        if (d_valid !== 1'b0 || d_wb !== 2'b00 || d_stall !== 1'b0)
            $display("FAIL lu_bubble: got v%b wb%b st%b exp v0 wb00 st0", d_valid, d_wb, d_stall);
        else pass_cnt++;
        total++;
        if (d_cnt !== 16'd1)
            $display("FAIL lu_count: got %0d exp 1", d_cnt);
        else pass_cnt++;
        step();
        total++;
        if (d_valid !== 1'b1 || d_wb !== 2'b10 || d_rd !== 5'd4 || d_cnt !== 16'd1)
            $display("FAIL lu_release: got v%b wb%b rd%0d cnt%0d exp v1 wb10 rd4 cnt1", d_valid, d_wb, d_rd, d_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush_over_stall();
        drive_id(1'b1, itype(OP_LW, 5'd1, 5'd7, 16'h8));
        step();
        drive_id(1'b1, rtype(5'd7, 5'd7, 5'd8));
        flush = 1'b1;
        #1;
        total++;
        if (d_stall !== 1'b1)
            $display("FAIL fl_stall: got %b exp 1", d_stall);
        else pass_cnt++;
        step();
        stalls++;
        total++;
        if ({d_valid, d_wb, d_mem, d_ex} !== 10'd0 || d_cnt !== 16'd2)
            $display("FAIL fl_bubble: got %b cnt %0d exp 0 cnt 2", {d_valid, d_wb, d_mem, d_ex}, d_cnt);
        else pass_cnt++;
        flush = 1'b0;
        drive_id(1'b1, itype(OP_SW, 5'd3, 5'd4, 16'h0));
        step();
        flush = 1'b1;
        step();
        total++;
        if (d_mem !== 3'b000 || d_valid !== 1'b0)
            $display("FAIL fl_plain: got mem%b v%b exp 000 v0", d_mem, d_valid);
        else pass_cnt++;
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive_id(1'b1, itype(OP_LW, 5'd1, 5'(10 + k), 16'h0));
            step();
            drive_id(1'b1, rtype(5'(10 + k), 5'd0, 5'd20));
            #1;
            total++;
            if (s_stall !== 1'b1)
                $display("FAIL sat_stall[%0d]: got %b exp 1", k, s_stall);
            else pass_cnt++;
            step();
            stalls++;
            total++;
            if (s_cnt !== ((stalls > 3) ? 2'd3 : 2'(stalls)) || d_cnt !== 16'(stalls))
                $display("FAIL sat_cnt[%0d]: got %0d/%0d exp %0d/%0d", k, s_cnt, d_cnt,
                         (stalls > 3) ? 3 : stalls, stalls);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        bubble();
        wb_reg_write = 1'b1; wb_loc = 5'd5; wb_data = 32'h0000_0055;
        drive_id(1'b1, rtype(5'd5, 5'd0, 5'd6));
        step();
        wb_reg_write = 1'b0;
        step();
        total++;
        if (d_rd1 !== 32'h55 || d_valid !== 1'b1)
            $display("FAIL mid_pre: got %h v%b exp 55 v1", d_rd1, d_valid);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({d_valid, d_wb, d_mem, d_ex} !== 10'd0 || d_rd1 !== 32'd0 || d_npc !== 32'd0 || d_rs !== 5'd0)
            $display("FAIL mid_async: got %b rd1 %h npc %h exp 0", {d_valid, d_wb, d_mem, d_ex}, d_rd1, d_npc);
        else pass_cnt++;
        total++;
        if (d_cnt !== 16'd0 || s_cnt !== 2'd0)
            $display("FAIL mid_cnt: got %0d/%0d exp 0/0", d_cnt, s_cnt);
        else pass_cnt++;
        step();
        total++;
        if (d_valid !== 1'b0)
            $display("FAIL mid_hold: got %b exp 0", d_valid);
        else pass_cnt++;
        rst = 1'b1;
        step();
        total++;
        if (d_rd1 !== 32'd0 || n_rd1 !== 32'd0 || d_valid !== 1'b1)
            $display("FAIL mid_r5: got %h %h v%b exp 0 0 v1", d_rd1, n_rd1, d_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_bypass();
        test_reg0();
        test_load_use();
        test_flush_over_stall();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised next-generation ID stage for the 5-stage MIPS pipeline; sits between the IF/ID latch and the execute stage.
- Contains a register file, a main control decoder and sign extension, feeding a registered ID/EX latch.
- Beyond the previous generation it adds:
  - configurable data width
  - WB-to-ID write-through bypass
  - load-use hazard detection with stall and bubble insertion
  - branch flush
  - valid tracking
  - a saturating stall-cycle counter

Parameters:
- DATA_W, 32, register/datapath width; sign extension targets this width (32 or 64).
- PC_W, 32, width of NPC values.
- BYPASS_EN, 1, 1 = same-cycle WB write is visible on read ports; 0 = read returns old value.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_reg_write  in  1  WB-stage register write enable.
- wb_write_reg_location  in  5  WB destination register.
- mem_wb_write_data  in  DATA_W  WB write data.
- if_id_instr  in  32  instruction from IF/ID.
- if_id_npc  in  PC_W  next PC from IF/ID.
- if_id_valid  in  1  IF/ID holds a real instruction.
- flush  in  1  branch taken; squash the instruction entering ID/EX.
- hazard_stall  out  1  combinational; holds PC and IF/ID when 1.
- id_ex_valid  out  1  ID/EX slot holds a real instruction.
- id_ex_wb  out  2  {regwrite, memtoreg}.
- id_ex_mem  out  3  {branch, memread, memwrite}.
- id_ex_execute  out  4  {regdst, aluop[1:0], alusrc}.
- id_ex_npc  out  PC_W  latched NPC.
- id_ex_read_data_1  out  DATA_W  latched rs value.
- id_ex_read_data_2  out  DATA_W  latched rt value.
- id_ex_sign_ext  out  DATA_W  latched sign-extended imm[15:0].
- id_ex_instr_bits_25_21  out  5  latched rs, for the forwarding unit.
- id_ex_instr_bits_20_16  out  5  latched rt.
- id_ex_instr_bits_15_11  out  5  latched rd.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - All 32 registers clear to 0.
  - Every id_ex_* output clears to 0, including id_ex_valid.
  - stall_count clears to 0.
- Register file:
  - 32 x DATA_W; register 0 reads 0 always; writes to register 0 are ignored.
  - Write occurs on the rising edge when wb_reg_write=1.
  - Reads are combinational.
  - If BYPASS_EN=1 and wb_reg_write=1 and wb_write_reg_location equals a nonzero read address, that port returns mem_wb_write_data in the same cycle.
- Control decode on opcode if_id_instr[31:26]; each entry lists wb / mem / ex:
  - 0x00 R-type: 10 / 000 / 1100
  - 0x23 lw: 11 / 010 / 0001
  - 0x2B sw: 00 / 001 / 0001
  - 0x04 beq: 00 / 100 / 0010
  - 0x08 addi: 10 / 000 / 0001
  - Any other opcode: all zero (NOP).
- Sign extension: replicate imm[15] into bits DATA_W-1:16.
- Load-use hazard:
  - hazard_stall = id_ex_valid & id_ex_mem[1] & if_id_valid & (id_ex_instr_bits_20_16 != 0) & (id_ex_instr_bits_20_16 == rs | id_ex_instr_bits_20_16 == rt).
  - Purely combinational; no registered state.
- ID/EX update each rising edge, in priority order:
  - flush=1: bubble. Control fields 0, id_ex_valid 0, data fields don't-care (implementation drives 0).
  - else hazard_stall=1: bubble as above.
  - else: latch decoded values; id_ex_valid = if_id_valid; control fields forced to 0 when if_id_valid=0.
- Stall latency:
  - A load-use stall lasts exactly one cycle: the bubble clears id_ex_valid, so hazard_stall drops the next cycle.
  - The held instruction then enters ID/EX with its operands. Forwarding supplies the load result; it is not handled in this block.
- Simultaneous flush and stall: flush wins; the stall is still asserted combinationally, and stall_count still increments.
- stall_count: increments by 1 on each edge where hazard_stall=1; saturates at all-ones; no wrap.
- Mid-operation reset: takes immediate effect regardless of stall or flush.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - control-field bit positions
  - the NOP control constant
- Sub-module: hz_reg_file, the parametrised register file with the BYPASS_EN write-through.
- The decoder, sign extension, hazard logic and latch stay inline.

Test Plan:
- Reset mid-run: drive rst=0 while id_ex_valid=1 -> all id_ex_* outputs 0, stall_count 0, and register 5 reads 0 immediately.
- Bypass: wb writes r3=0xDEADBEEF while ID decodes add r1,r3,r0 (BYPASS_EN=1) -> next edge id_ex_read_data_1=0xDEADBEEF; with BYPASS_EN=0 -> the old value 0.
- Load-use: lw r2,4(r1) in ID/EX, then add r4,r2,r5 in ID -> hazard_stall=1 for exactly one cycle, bubble latched (id_ex_wb=0, id_ex_valid=0), add latches the following cycle, stall_count=1.
- Flush over stall: hazard condition present with flush=1 -> ID/EX bubble, stall_count increments, no spurious write controls.
- Register 0: wb writes r0=0x1234 -> later read of r0 gives 0; lw into r0 followed by a consumer of r0 -> no stall.
- Saturation: STALL_CNT_W=2, five consecutive load-use pairs -> stall_count sticks at 3.
